// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority over the
// long-latency unit, with a busy scoreboard for RAW stalls and starvation hold control.
module regs_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   output logic        pipe_hold_o,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_waddr_i,
   input  logic [31:0] lu_wdata_i,
   output logic        lu_ready_o,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_rd_i,
   input  logic [4:0]  id_reg1_raddr_i,
   input  logic [4:0]  id_reg2_raddr_i,
   output logic        id_stall_o,
   output logic        wb_reg_we_o,
   output logic [4:0]  wb_reg_waddr_o,
   output logic [31:0] wb_reg_wdata_o,
   output logic [31:0] busy_o
);

   localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

   logic [31:0] busy_q, busy_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        hold_q, hold_d;
   logic        lu_xfer;
   logic        lu_blocked;
   logic        sel_we;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'd1;
   endfunction

   assign lu_ready_o = !pipe_we_i;
   assign lu_xfer    = lu_valid_i && !pipe_we_i;
   assign lu_blocked = lu_valid_i && pipe_we_i;

   always_comb begin
      sel_we         = 1'b0;
      wb_reg_waddr_o = 5'd0;
      wb_reg_wdata_o = 32'd0;
      if (pipe_we_i) begin
         sel_we         = 1'b1;
         wb_reg_waddr_o = pipe_waddr_i;
         wb_reg_wdata_o = pipe_wdata_i;
      end else if (lu_xfer) begin
         sel_we         = 1'b1;
         wb_reg_waddr_o = lu_waddr_i;
         wb_reg_wdata_o = lu_wdata_i;
      end
   end

   // x0 is hardwired zero; the handshake still completes, only the write is dropped
   assign wb_reg_we_o = sel_we && (wb_reg_waddr_o != 5'd0);

   always_comb begin
      busy_d = busy_q;
      if (lu_xfer && lu_waddr_i != 5'd0)
         busy_d[lu_waddr_i] = 1'b0;
      // a newly issued op overrides a completing one on the same register
      if (iss_valid_i && iss_rd_i != 5'd0)
         busy_d[iss_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      wait_cnt_d = lu_blocked ? sat_inc4(wait_cnt_q) : 4'd0;
      hold_d     = hold_q;
      if (lu_blocked && ({1'b0, wait_cnt_q} + 5'd1 >= LIMIT))
         hold_d = 1'b1;
      else if (lu_xfer || !lu_valid_i)
         hold_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 32'd0;
         wait_cnt_q <= 4'd0;
         hold_q     <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         wait_cnt_q <= wait_cnt_d;
         hold_q     <= hold_d;
      end
   end

   assign busy_o      = busy_q;
   assign pipe_hold_o = hold_q;
   assign id_stall_o  = ((id_reg1_raddr_i != 5'd0) && busy_q[id_reg1_raddr_i]) ||
                        ((id_reg2_raddr_i != 5'd0) && busy_q[id_reg2_raddr_i]);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: arbitration, x0, scoreboard, starvation hold, async reset.
module tb_regs_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        pipe_we_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        pipe_hold_o;
   logic        lu_valid_i;
   logic [4:0]  lu_waddr_i;
   logic [31:0] lu_wdata_i;
   logic        lu_ready_o;
   logic        iss_valid_i;
   logic [4:0]  iss_rd_i;
   logic [4:0]  id_reg1_raddr_i;
   logic [4:0]  id_reg2_raddr_i;
   logic        id_stall_o;
   logic        wb_reg_we_o;
   logic [4:0]  wb_reg_waddr_o;
   logic [31:0] wb_reg_wdata_o;
   logic [31:0] busy_o;

   int checks = 0;
   int failures = 0;

   regs_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
      .pipe_hold_o(pipe_hold_o),
      .lu_valid_i(lu_valid_i), .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
      .lu_ready_o(lu_ready_o),
      .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i),
      .id_reg1_raddr_i(id_reg1_raddr_i), .id_reg2_raddr_i(id_reg2_raddr_i),
      .id_stall_o(id_stall_o),
      .wb_reg_we_o(wb_reg_we_o), .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_wdata_o(wb_reg_wdata_o),
      .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
      lu_valid_i = 0; lu_waddr_i = 0; lu_wdata_i = 0;
      iss_valid_i = 0; iss_rd_i = 0;
      id_reg1_raddr_i = 0; id_reg2_raddr_i = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #3;
      chk("rst_busy", busy_o, 32'h0);
      chk("rst_hold", {31'd0, pipe_hold_o}, 32'd0);
      chk("rst_we", {31'd0, wb_reg_we_o}, 32'd0);
      chk("rst_lu_ready", {31'd0, lu_ready_o}, 32'd1);
      #9 rst_n = 1'b1;
      tick();

      // 1: pipe write goes straight through
      pipe_we_i = 1; pipe_waddr_i = 5; pipe_wdata_i = 32'hA5A5_0001;
      #1;
      chk("t1_we", {31'd0, wb_reg_we_o}, 32'd1);
      chk("t1_waddr", {27'd0, wb_reg_waddr_o}, 32'd5);
      chk("t1_wdata", wb_reg_wdata_o, 32'hA5A5_0001);
      chk("t1_lu_ready", {31'd0, lu_ready_o}, 32'd0);
      tick();

      // 2: pipe beats lu, lu goes next cycle
      pipe_we_i = 1; pipe_waddr_i = 3; pipe_wdata_i = 32'h11;
      lu_valid_i = 1; lu_waddr_i = 7; lu_wdata_i = 32'h22;
      #1;
      chk("t2_c1_waddr", {27'd0, wb_reg_waddr_o}, 32'd3);
      chk("t2_c1_wdata", wb_reg_wdata_o, 32'h11);
      chk("t2_c1_lu_ready", {31'd0, lu_ready_o}, 32'd0);
      tick();
      pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
      #1;
      chk("t2_c2_we", {31'd0, wb_reg_we_o}, 32'd1);
      chk("t2_c2_waddr", {27'd0, wb_reg_waddr_o}, 32'd7);
      chk("t2_c2_wdata", wb_reg_wdata_o, 32'h22);
      chk("t2_c2_lu_ready", {31'd0, lu_ready_o}, 32'd1);
      tick();
      idle();
      #1;
      chk("idle_we", {31'd0, wb_reg_we_o}, 32'd0);
      chk("idle_wdata", wb_reg_wdata_o, 32'h0);

      // x0: lu transfer handshakes but never writes
      lu_valid_i = 1; lu_waddr_i = 0; lu_wdata_i = 32'hDEAD;
      #1;
      chk("x0_lu_we", {31'd0, wb_reg_we_o}, 32'd0);
      chk("x0_lu_ready", {31'd0, lu_ready_o}, 32'd1);
      tick();
      idle();
      pipe_we_i = 1; pipe_waddr_i = 0; pipe_wdata_i = 32'hBEEF;
      #1;
      chk("x0_pipe_we", {31'd0, wb_reg_we_o}, 32'd0);
      tick();
      idle();

      // 3: issue to x9, stall, clear via lu, no bypass
      iss_valid_i = 1; iss_rd_i = 9;
      tick();
      iss_valid_i = 0; iss_rd_i = 0; id_reg1_raddr_i = 9;
      #1;
      chk("t3_busy", busy_o, 32'h0000_0200);
      chk("t3_stall", {31'd0, id_stall_o}, 32'd1);
      lu_valid_i = 1; lu_waddr_i = 9; lu_wdata_i = 32'h99;
      #1;
      chk("t3_no_bypass", {31'd0, id_stall_o}, 32'd1);
      tick();
      lu_valid_i = 0;
      #1;
      chk("t3_busy_clr", busy_o, 32'h0);
      chk("t3_stall_clr", {31'd0, id_stall_o}, 32'd0);
      idle();
      id_reg2_raddr_i = 9;
      #1;
      chk("t3_stall_r2_idle", {31'd0, id_stall_o}, 32'd0);
      idle();

      // 4: set wins over clear; x0 issue ignored
      iss_valid_i = 1; iss_rd_i = 4;
      tick();
      lu_valid_i = 1; lu_waddr_i = 4; lu_wdata_i = 32'h44;
      tick();
      idle();
      #1;
      chk("t4_set_wins", busy_o, 32'h0000_0010);
      iss_valid_i = 1; iss_rd_i = 0;
      tick();
      idle();
      #1;
      chk("t4_x0_issue", busy_o, 32'h0000_0010);
      id_reg1_raddr_i = 0; id_reg2_raddr_i = 0;
      #1;
      chk("t4_x0_nostall", {31'd0, id_stall_o}, 32'd0);
      id_reg2_raddr_i = 4;
      #1;
      chk("t4_r2_stall", {31'd0, id_stall_o}, 32'd1);
      idle();
      lu_valid_i = 1; lu_waddr_i = 4;
      tick();
      idle();
      #1;
      chk("t4_clear", busy_o, 32'h0);

      // 5: starvation; hold rises after 4th blocked cycle
      lu_valid_i = 1; lu_waddr_i = 2; lu_wdata_i = 32'h2222;
      pipe_we_i = 1; pipe_waddr_i = 1; pipe_wdata_i = 32'h1111;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t5_hold_low%0d", i), {31'd0, pipe_hold_o}, 32'd0);
         tick();
      end
      #1;
      chk("t5_hold_high", {31'd0, pipe_hold_o}, 32'd1);
      chk("t5_pipe_still_wins", {27'd0, wb_reg_waddr_o}, 32'd1);
      tick();
      #1;
      chk("t5_hold_kept", {31'd0, pipe_hold_o}, 32'd1);
      pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
      #1;
      chk("t5_xfer_ready", {31'd0, lu_ready_o}, 32'd1);
      chk("t5_xfer_waddr", {27'd0, wb_reg_waddr_o}, 32'd2);
      chk("t5_xfer_wdata", wb_reg_wdata_o, 32'h2222);
      tick();
      idle();
      #1;
      chk("t5_hold_drop", {31'd0, pipe_hold_o}, 32'd0);

      // 6: async reset mid-stall
      iss_valid_i = 1; iss_rd_i = 8;
      tick();
      iss_rd_i = 9;
      tick();
      idle();
      lu_valid_i = 1; lu_waddr_i = 5; pipe_we_i = 1; pipe_waddr_i = 6;
      repeat (4) tick();
      #1;
      chk("t6_pre_busy", busy_o, 32'h0000_0300);
      chk("t6_pre_hold", {31'd0, pipe_hold_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy_o, 32'h0);
      chk("t6_rst_hold", {31'd0, pipe_hold_o}, 32'd0);
      idle();
      tick();
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
